// File: rtl/ma_stage_if.sv
// rtl/ma_stage_if.sv - data-memory request/acknowledge port between the MA stage and memory
interface ma_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // Pipeline side: issues requests, receives load data and completion
    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    // Memory side: services requests
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/ma_stage.sv
// rtl/ma_stage.sv - memory-access pipeline stage with bounded wait and sticky error flag
module ma_stage #(
    parameter int CB_WIDTH       = 22,
    parameter int LD_BIT         = 1,
    parameter int ST_BIT         = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [31:0]         in_PC,
    input  logic [31:0]         in_ALU_Result,
    input  logic [31:0]         in_op2,
    input  logic [31:0]         in_IR,
    input  logic [CB_WIDTH-1:0] in_controlBus,
    ma_stage_if.master          mem,
    output logic                ma_stall,
    output logic                out_valid,
    output logic [31:0]         out_PC,
    output logic [31:0]         out_ALU_Result,
    output logic [31:0]         out_ld_result,
    output logic [31:0]         out_IR,
    output logic [CB_WIDTH-1:0] out_controlBus,
    output logic                mem_error
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [31:0]           mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  out_valid_q;
    logic [31:0]           out_pc_q;
    logic [31:0]           out_alu_q;
    logic [31:0]           out_ld_q;
    logic [31:0]           out_ir_q;
    logic [CB_WIDTH-1:0]   out_cb_q;
    logic                  mem_error_q;

    logic is_ld;
    logic is_st;
    logic memop;
    logic misaligned;
    logic timeout_hit;

    // Instruction classification; a store wins if both load and store bits are set
    always_comb begin
        is_ld       = in_controlBus[LD_BIT];
        is_st       = in_controlBus[ST_BIT];
        memop       = in_valid & (is_ld | is_st);
        misaligned  = |in_ALU_Result[1:0];
        timeout_hit = (cnt_q == CNT_MAX);
        cnt_d       = cnt_q + 1'b1;
    end

    // Hold upstream while an aligned access is launching or still outstanding
    always_comb begin
        ma_stall = 1'b0;
        if (state_q == S_IDLE) begin
            ma_stall = memop & ~misaligned;
        end else begin
            ma_stall = ~mem.mem_ack & ~timeout_hit;
        end
    end

    // Stage FSM: launches accesses, waits for ack or timeout, registers results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_alu_q   <= '0;
            out_ld_q    <= '0;
            out_ir_q    <= '0;
            out_cb_q    <= '0;
            mem_error_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!in_valid) begin
                        out_valid_q <= 1'b0;
                    end else if (!memop || misaligned) begin
                        // Non-memory ops and misaligned accesses complete in one edge
                        out_valid_q <= 1'b1;
                        out_pc_q    <= in_PC;
                        out_alu_q   <= in_ALU_Result;
                        out_ld_q    <= '0;
                        out_ir_q    <= in_IR;
                        out_cb_q    <= in_controlBus;
                        if (memop) begin
                            mem_error_q <= 1'b1;
                        end
                    end else begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_st;
                        mem_addr_q  <= in_ALU_Result;
                        mem_wdata_q <= in_op2;
                        out_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_ack || timeout_hit) begin
                        // Upstream is stable during WAIT, so inputs still describe this instruction
                        out_valid_q <= 1'b1;
                        out_pc_q    <= in_PC;
                        out_alu_q   <= in_ALU_Result;
                        out_ir_q    <= in_IR;
                        out_cb_q    <= in_controlBus;
                        mem_req_q   <= 1'b0;
                        state_q     <= S_IDLE;
                        if (mem.mem_ack) begin
                            out_ld_q <= mem_we_q ? 32'd0 : mem.mem_rdata;
                        end else begin
                            out_ld_q    <= '0;
                            mem_error_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign out_valid      = out_valid_q;
    assign out_PC         = out_pc_q;
    assign out_ALU_Result = out_alu_q;
    assign out_ld_result  = out_ld_q;
    assign out_IR         = out_ir_q;
    assign out_controlBus = out_cb_q;
    assign mem_error      = mem_error_q;
endmodule
